// File: rtl/fifo_512_60bit_arb_ctrl.sv
// Round-robin write arbiter in front of a shared 512x60 FIFO, with a 2-entry
// valid/ready output buffer that hides the FIFO's registered read latency.

module fifo_512_60bit #(
    parameter int unsigned aw = 9,
    parameter int unsigned dw = 60
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic [dw-1:0] din,
    input  logic          we,
    output logic [dw-1:0] dout,
    input  logic          re,
    output logic          full,
    output logic          empty
);
    localparam int unsigned DEPTH = 1 << aw;
    localparam int unsigned CW    = aw + 1;

    logic [dw-1:0] mem [DEPTH];
    logic [aw-1:0] wp;
    logic [aw-1:0] rp;
    logic [CW-1:0] cnt;
    logic          do_we;
    logic          do_re;

    assign full  = (cnt == CW'(DEPTH));
    assign empty = (cnt == '0);
    assign do_we = we & ~full & ~clr;
    assign do_re = re & ~empty & ~clr;

    always_ff @(posedge clk) begin
        if (do_we) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            if (do_we) begin
                wp <= wp + aw'(1);
            end
            if (do_re) begin
                rp <= rp + aw'(1);
            end
            case ({do_we, do_re})
                2'b10:   cnt <= cnt + CW'(1);
                2'b01:   cnt <= cnt - CW'(1);
                default: cnt <= cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout <= '0;
        end else if (do_re) begin
            dout <= mem[rp];
        end
    end
endmodule

module fifo_512_60bit_arb_ctrl #(
    parameter int unsigned NREQ      = 4,
    parameter int unsigned DW        = 60,
    parameter int unsigned AW        = 9,
    parameter int unsigned AF_THRESH = 480
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic [NREQ-1:0]          wr_valid,
    input  logic [NREQ*DW-1:0]       wr_data,
    output logic [NREQ-1:0]          wr_ready,
    output logic                     rd_valid,
    output logic [DW-1:0]            rd_data,
    input  logic                     rd_ready,
    output logic [AW:0]              level,
    output logic                     almost_full,
    output logic [$clog2(NREQ)-1:0]  last_grant
);
    localparam int unsigned LW    = AW + 1;
    localparam int unsigned GW    = $clog2(NREQ);
    localparam int unsigned DEPTH = 1 << AW;

    logic [GW-1:0] rr;
    logic [GW-1:0] gidx;
    logic [GW-1:0] cidx;
    int unsigned   cand;
    logic          found;
    logic          space;
    logic          we;
    logic          re;
    logic          inflight;
    logic          pop;
    logic          cap;
    logic [1:0]    ob_count;
    logic [1:0]    ob_count_nxt;
    logic [DW-1:0] ob1;
    logic [DW-1:0] fifo_din;
    logic [DW-1:0] fifo_dout;
    logic          fifo_full;
    logic          fifo_empty;
    logic [LW-1:0] level_nxt;

    fifo_512_60bit #(.aw(AW), .dw(DW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .din   (fifo_din),
        .we    (we),
        .dout  (fifo_dout),
        .re    (re),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Space is judged on the registered level only; a same-cycle read never frees a slot.
    assign space = (level < LW'(DEPTH)) & ~fifo_full;

    // Cyclic priority search starting just after the last granted requester.
    always_comb begin
        found = 1'b0;
        gidx  = '0;
        cand  = 0;
        cidx  = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            cand = (32'(rr) + i) % NREQ;
            cidx = GW'(cand);
            if (!found && wr_valid[cidx]) begin
                found = 1'b1;
                gidx  = cidx;
            end
        end
    end

    assign we       = found & space & ~clr & ~rst;
    assign wr_ready = we ? (NREQ'(1) << gidx) : '0;

    always_comb begin
        fifo_din = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (gidx == GW'(i)) begin
                fifo_din = wr_data[i*DW +: DW];
            end
        end
    end

    // Keep at most two words between the buffer and the FIFO's read pipeline.
    assign re  = (level != '0) & ~fifo_empty & ((3'(ob_count) + 3'(inflight)) < 3'd2)
                 & ~clr & ~rst;
    assign pop = rd_valid & rd_ready;
    assign cap = inflight;

    assign ob_count_nxt = ob_count + 2'(cap) - 2'(pop);

    always_comb begin
        level_nxt = level;
        case ({we, re})
            2'b10:   level_nxt = level + LW'(1);
            2'b01:   level_nxt = level - LW'(1);
            default: level_nxt = level;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level       <= '0;
            almost_full <= 1'b0;
            rr          <= GW'(NREQ - 1);
            last_grant  <= '0;
        end else if (clr) begin
            level       <= '0;
            almost_full <= 1'b0;
            rr          <= GW'(NREQ - 1);
        end else begin
            level       <= level_nxt;
            almost_full <= (level_nxt >= LW'(AF_THRESH));
            if (we) begin
                rr         <= gidx;
                last_grant <= gidx;
            end
        end
    end

    // rd_data is the head register; it keeps its value when the buffer is flushed.
    always_ff @(posedge clk) begin
        if (rst) begin
            ob_count <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            ob1      <= '0;
            inflight <= 1'b0;
        end else if (clr) begin
            ob_count <= '0;
            rd_valid <= 1'b0;
            inflight <= 1'b0;
        end else begin
            inflight <= re;
            ob_count <= ob_count_nxt;
            rd_valid <= (ob_count_nxt != 2'd0);
            if (pop) begin
                if (ob_count == 2'd2) begin
                    rd_data <= ob1;
                    if (cap) begin
                        ob1 <= fifo_dout;
                    end
                end else if (cap) begin
                    rd_data <= fifo_dout;
                end
            end else if (cap) begin
                if (ob_count == 2'd0) begin
                    rd_data <= fifo_dout;
                end else begin
                    ob1 <= fifo_dout;
                end
            end
        end
    end
endmodule

// File: tb/tb_fifo_512_60bit_arb_ctrl.sv
// Directed bench for fifo_512_60bit_arb_ctrl: arbitration order, latency,
// full boundary, backpressure and flush behaviour.

module tb_fifo_512_60bit_arb_ctrl;
    localparam int unsigned NREQ = 4;
    localparam int unsigned DW   = 60;
    localparam int unsigned AW   = 9;

    logic               clk;
    logic               rst;
    logic               clr;
    logic [NREQ-1:0]    wr_valid;
    logic [NREQ*DW-1:0] wr_data;
    logic [NREQ-1:0]    wr_ready;
    logic               rd_valid;
    logic [DW-1:0]      rd_data;
    logic               rd_ready;
    logic [AW:0]        level;
    logic               almost_full;
    logic [1:0]         last_grant;

    int checks = 0;
    int errors = 0;
    int acc    = 0;
    logic [DW-1:0] rdq[$];

    fifo_512_60bit_arb_ctrl #(.NREQ(NREQ), .DW(DW), .AW(AW), .AF_THRESH(480)) dut (
        .clk         (clk),
        .rst         (rst),
        .clr         (clr),
        .wr_valid    (wr_valid),
        .wr_data     (wr_data),
        .wr_ready    (wr_ready),
        .rd_valid    (rd_valid),
        .rd_data     (rd_data),
        .rd_ready    (rd_ready),
        .level       (level),
        .almost_full (almost_full),
        .last_grant  (last_grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Record accepted output words and accepted writes mid-cycle.
    always @(negedge clk) begin
        if (!rst && !clr) begin
            if (rd_valid && rd_ready) rdq.push_back(rd_data);
            acc = acc + $countones(wr_valid & wr_ready);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_lane(input int i, input logic [DW-1:0] v);
        wr_data[i*DW +: DW] = v;
    endtask

    initial begin
        logic          prev_stall;
        logic [DW-1:0] prev_data;

        rst = 1'b1; clr = 1'b0; rd_ready = 1'b0;
        wr_valid = 4'b1111; wr_data = '0;
        step();
        step();
        chk("rst_wr_ready", 64'(wr_ready), 64'h0);
        rst = 1'b0; wr_valid = 4'b0000;
        #1;
        chk("rst_level", 64'(level), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", 64'(rd_data), 64'd0);
        chk("rst_af", 64'(almost_full), 64'd0);
        chk("rst_last_grant", 64'(last_grant), 64'd0);

        // Single write and pipeline latency
        wr_valid = 4'b0001; set_lane(0, 60'hABC);
        #1;
        chk("single_grant", 64'(wr_ready), 64'h1);
        step();
        wr_valid = 4'b0000;
        chk("single_level1", 64'(level), 64'd1);
        step();
        chk("single_level0", 64'(level), 64'd0);
        chk("single_not_yet", 64'(rd_valid), 64'd0);
        step();
        chk("single_rd_valid", 64'(rd_valid), 64'd1);
        chk("single_rd_data", 64'(rd_data), 64'hABC);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("single_popped", 64'(rd_valid), 64'd0);

        // Flush restores requester 0 priority; then round-robin
        clr = 1'b1; wr_valid = 4'b1111;
        for (int i = 0; i < 4; i++) set_lane(i, 60'h1000 + 60'(i));
        #1;
        chk("clr_no_grant", 64'(wr_ready), 64'h0);
        step();
        clr = 1'b0; rd_ready = 1'b1;
        rdq.delete();
        chk("clr_level", 64'(level), 64'd0);
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_grant", 64'(wr_ready), 64'(4'b0001 << (k % 4)));
            step();
        end
        wr_valid = 4'b0000;
        chk("rr_last_grant", 64'(last_grant), 64'd3);
        for (int c = 0; c < 30 && rdq.size() < 8; c++) step();
        chk("rr_count", 64'(rdq.size()), 64'd8);
        for (int k = 0; k < 8 && k < rdq.size(); k++)
            chk("rr_data", 64'(rdq[k]), 64'h1000 + 64'(k % 4));

        // Fill to the full boundary with the consumer stalled
        rd_ready = 1'b0; acc = 0; rdq.delete();
        wr_valid = 4'b0100;
        for (int c = 0; c < 600; c++) begin
            set_lane(2, 60'(acc));
            #1;
            chk("full_level_max", 64'(level <= 10'd512), 64'd1);
            chk("full_af", 64'(almost_full), 64'(level >= 10'd480));
            chk("full_no_we", 64'(wr_ready & {4{level == 10'd512}}), 64'h0);
            step();
        end
        chk("full_accepted", 64'(acc), 64'd514);
        chk("full_level", 64'(level), 64'd512);
        chk("full_af_hi", 64'(almost_full), 64'd1);
        chk("full_wr_ready", 64'(wr_ready), 64'h0);
        chk("full_rd_valid", 64'(rd_valid), 64'd1);
        chk("full_head", 64'(rd_data), 64'd0);

        // One read at level 512: write only admitted the following cycle
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        chk("sim_same_cycle", 64'(wr_ready), 64'h0);
        step();
        chk("sim_level511", 64'(level), 64'd511);
        chk("sim_next_grant", 64'(wr_ready), 64'h4);
        step();
        wr_valid = 4'b0000;
        chk("sim_level512", 64'(level), 64'd512);
        chk("sim_popped_n", 64'(rdq.size()), 64'd1);
        chk("sim_popped_d", 64'(rdq.size() > 0 ? rdq[0] : 60'hFFF), 64'd0);

        // Flush, then build level=100 with a word in flight
        clr = 1'b1;
        step();
        clr = 1'b0;
        chk("flush_level", 64'(level), 64'd0);
        chk("flush_rd_valid", 64'(rd_valid), 64'd0);
        chk("flush_af", 64'(almost_full), 64'd0);
        for (int k = 0; k < 103; k++) begin
            wr_valid = 4'b0010; set_lane(1, 60'h2000 + 60'(k));
            step();
        end
        wr_valid = 4'b0000;
        step(); step(); step();
        chk("mid_level101", 64'(level), 64'd101);
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        step();
        chk("mid_level100", 64'(level), 64'd100);
        clr = 1'b1; wr_valid = 4'b0010;
        #1;
        chk("mid_clr_no_grant", 64'(wr_ready), 64'h0);
        step();
        clr = 1'b0; wr_valid = 4'b0000;
        chk("mid_level0", 64'(level), 64'd0);
        chk("mid_rd_valid", 64'(rd_valid), 64'd0);
        chk("mid_rd_data_hold", 64'(rd_data), 64'h2001);
        wr_valid = 4'b0001; set_lane(0, 60'h5);
        #1;
        chk("mid_grant0", 64'(wr_ready), 64'h1);
        step();
        wr_valid = 4'b0000;
        rdq.delete();
        rd_ready = 1'b1;
        for (int c = 0; c < 10 && rdq.size() == 0; c++) step();
        chk("mid_first_n", 64'(rdq.size()), 64'd1);
        chk("mid_first_d", 64'(rdq.size() > 0 ? rdq[0] : 60'hFFF), 64'h5);

        // Backpressure: ten words, consumer toggles every cycle
        rd_ready = 1'b0; rdq.delete();
        for (int k = 0; k < 10; k++) begin
            wr_valid = 4'b1000; set_lane(3, 60'h3000 + 60'(k));
            step();
        end
        wr_valid = 4'b0000;
        prev_stall = 1'b0; prev_data = '0;
        for (int c = 0; c < 40; c++) begin
            if (prev_stall) begin
                chk("bp_hold_valid", 64'(rd_valid), 64'd1);
                chk("bp_hold_data", 64'(rd_data), 64'(prev_data));
            end
            rd_ready   = (c % 2 == 0);
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            step();
        end
        rd_ready = 1'b0;
        chk("bp_count", 64'(rdq.size()), 64'd10);
        for (int k = 0; k < 10 && k < rdq.size(); k++)
            chk("bp_data", 64'(rdq[k]), 64'h3000 + 64'(k));
        chk("bp_level", 64'(level), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/fifo_512_60bit_arb_ctrl.md
Name: fifo_512_60bit_arb_ctrl

Overview:
Shares one 512x60 FIFO (instance of fifo_512_60bit, aw=9, dw=60) between NREQ write requesters using round-robin arbitration. On the read side it converts the FIFO's raw re/dout interface (dout registered, one cycle after re) into a valid/ready output stream through a 2-entry output buffer. It tracks its own occupancy, so the FIFO's full/empty flags are never violated. It sits between producer lanes and a single downstream consumer in the accelerator datapath.

Parameters:
NREQ, 4, number of write requesters (2..8)
DW, 60, data width, passed to the FIFO
AW, 9, FIFO address width; depth = 1<<AW = 512
AF_THRESH, 480, level at or above which almost_full asserts

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous, active-high reset
clr  in  1  synchronous flush, same effect as rst on state (see Behaviour)
wr_valid  in  NREQ  per-requester write request
wr_data  in  NREQ*DW  packed write data, requester i at [i*DW +: DW]
wr_ready  out  NREQ  one-hot grant; a write transfers when wr_valid[i] & wr_ready[i]
rd_valid  out  1  output word available
rd_data  out  DW  output word (head of output buffer)
rd_ready  in  1  consumer accepts when rd_valid & rd_ready
level  out  AW+1  words resident in the FIFO RAM (0..512), excludes in-flight and output-buffer words
almost_full  out  1  level >= AF_THRESH
last_grant  out  clog2(NREQ)  index of the most recently granted requester

Behaviour:
- Reset (rst=1): level=0, rr pointer=NREQ-1 (so requester 0 has first priority), last_grant=0, output buffer empty, in-flight flag=0, rd_valid=0, rd_data=0, wr_ready=0, almost_full=0. The FIFO is reset through its rst.
- Write arbitration (combinational):
  - space = (level_next_without_write < 512), evaluated against the current level, ignoring same-cycle reads.
  - If space & !clr & !rst, grant the first i with wr_valid[i], searching cyclically from rr+1. wr_ready is that one-hot grant; otherwise all zeros.
  - A full FIFO never receives we. A read in the same cycle does not free space for that cycle's write.
- On a transfer: FIFO we=1 with din=wr_data[grant]; rr and last_grant are set to the granted index. At most one write per cycle.
- Fairness: with all requesters continuously valid and space available, grants cycle 0,1,...,NREQ-1,0,...
- Read sequencer:
  - Issue re when level>0 & (ob_count + inflight) < 2.
  - inflight is set the cycle after re. The FIFO dout is captured into the output buffer on that cycle.
  - Latency from FIFO entry to rd_valid is 3 cycles minimum: write at t, re at t+1, capture at t+2, rd_valid at t+2 visible from the buffer register (t+3 relative to write edge).
- Output buffer: 2-entry FIFO, in order. rd_valid = ob_count>0. rd_data = head entry. Capture and pop may occur in the same cycle.
- level: +1 on we, -1 on re, unchanged when both occur. It never exceeds 512 and never underflows.
- almost_full: registered-level compare, updated with level.
- clr: same cycle drives FIFO clr=1. Next cycle: level=0, output buffer emptied, inflight=0, rr=NREQ-1. wr_ready=0 and re=0 during the clr cycle. A word in flight during clr is discarded. rd_valid drops the cycle after clr.
- rst or clr mid-stream: no partial word is ever presented; rd_data holds its last value but rd_valid=0.
- rd_ready may toggle freely. rd_data and rd_valid are stable while rd_valid & !rd_ready.

Test Plan:
- Reset then single write: wr_valid=4'b0001, data 60'hABC for 1 cycle -> wr_ready[0]=1 same cycle; level=1 next cycle; rd_valid=1 with rd_data=60'hABC within 3 cycles; level returns to 0.
- Round-robin: all 4 wr_valid held high for 8 cycles, rd_ready=1 -> grant order 0,1,2,3,0,1,2,3; output stream in that order with per-requester data values intact.
- Full boundary: rd_ready=0, requester 2 writes 600 cycles -> exactly 514 accepted (512 RAM + 2 output buffer); wr_ready=0 once level=512; almost_full rises when level reaches 480; no we while full.
- Backpressure: fill 10 words, toggle rd_ready 1/0 each cycle -> all 10 words received once, in order; rd_data stable during stalls.
- Simultaneous read/write at level=512: one read frees space; the write is granted the following cycle, not the same cycle; level stays in 511..512.
- clr mid-stream with level=100 and a word in flight -> next cycle level=0, rd_valid=0; a new write 60'h5 then emerges as the first output word.
